bht_ctrl: RTL

Controller sequencing a single-port branch history table (BHT) array of 2-bit saturating counters. It arbitrates between IF-stage prediction lookups and EX-stage resolution updates, buffers pending counter writes in a small queue, and initialises the array after reset or flush with a clear walker. It sits between the fetch/execute pipeline and the BHT storage macro.

---
 rtl/bht_pkg.sv | 23 ++
 rtl/bht_ctrl_if.sv | 39 +++
 rtl/bht_upd_fifo.sv | 73 +++++++
 rtl/bht_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// bht_pkg: shared types and helpers for the BHT controller.
//   cnt_t       2-bit saturating branch counter
//   CNT_INIT    value the clear walker writes (weakly not-taken)
//   state_t     controller state: CLEAR (init walk) / RUN
//   sat_update  next counter value after a resolved branch
package bht_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_INIT = 2'b01;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Saturating increment on taken, saturating decrement on not-taken.
  function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/bht_ctrl_if.sv
// bht_ctrl_if: pipeline-side handshake bundle of the BHT controller.
//   flush_req / clear_busy                      flush request, clear walk status
//   pred_req / pred_pc / pred_ready             IF-stage lookup request
//   pred_valid / pred_taken / pred_cnt / pred_idx  lookup result (1 cycle later)
//   upd_valid / upd_ready / upd_idx / upd_cnt / upd_taken  EX-stage resolution
// Modports: master = pipeline, slave = controller.
interface bht_ctrl_if #(
  parameter int IDX_W = 7
);
  import bht_pkg::*;

  logic             flush_req;
  logic             clear_busy;

  logic             pred_req;
  logic [31:0]      pred_pc;
  logic             pred_ready;
  logic             pred_valid;
  logic             pred_taken;
  cnt_t             pred_cnt;
  logic [IDX_W-1:0] pred_idx;

  logic             upd_valid;
  logic             upd_ready;
  logic [IDX_W-1:0] upd_idx;
  cnt_t             upd_cnt;
  logic             upd_taken;

  modport master (
    output flush_req, pred_req, pred_pc, upd_valid, upd_idx, upd_cnt, upd_taken,
    input  clear_busy, pred_ready, pred_valid, pred_taken, pred_cnt, pred_idx, upd_ready
  );

  modport slave (
    input  flush_req, pred_req, pred_pc, upd_valid, upd_idx, upd_cnt, upd_taken,
    output clear_busy, pred_ready, pred_valid, pred_taken, pred_cnt, pred_idx, upd_ready
  );

endinterface

// File: rtl/bht_upd_fifo.sv
// bht_upd_fifo: small FIFO buffering pending counter writes {idx, cnt}.
//   clk, reset_n   clock, asynchronous active-low reset
//   clear_i        synchronous flush (drops all entries)
//   push_i         enqueue wdata_i (ignored when full unless popping)
//   pop_i          dequeue head (ignored when empty)
//   wdata_i        entry to enqueue
//   rdata_o        head entry
//   full_o         occupancy == DEPTH
//   empty_o        occupancy == 0
module bht_upd_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A push on a full queue is legal when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy/pointers guard every read, so
  // resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bht_ctrl.sv
// bht_ctrl: sequencer for a single-port BHT array of 2-bit counters.
// Arbitrates IF lookups against queued EX counter writes, and walks the
// array writing CNT_INIT after reset or flush.
//   clk, reset_n   clock, asynchronous active-low reset
//   pipe           bht_ctrl_if.slave: lookup/update handshakes, flush, clear_busy
//   tbl_en/tbl_we  array port enable / write enable
//   tbl_addr       array address
//   tbl_wdata      array write data
//   tbl_rdata      array read data, one cycle after a read
// Build option: define BHT_GSHARE_EN to XOR a global history register
// (G_DEPTH bits, newest outcome in LSB) into the low lookup index bits.
module bht_ctrl
  import bht_pkg::*;
#(
  parameter int DEPTH    = 128,
  parameter int G_DEPTH  = 4,
  parameter int UQ_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  bht_ctrl_if.slave                pipe,
  output logic                     tbl_en,
  output logic                     tbl_we,
  output logic [$clog2(DEPTH)-1:0] tbl_addr,
  output cnt_t                     tbl_wdata,
  input  cnt_t                     tbl_rdata
);

  localparam int IDX_W = $clog2(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  state_t state_q;
  idx_t   clear_idx_q;
  logic   pred_valid_q;
  idx_t   pred_idx_q;

  idx_t   lookup_idx, head_idx;
  cnt_t   head_cnt, upd_next, pred_cnt_w;
  logic   accept_ok, drain, lookup, upd_fire, push;
  logic   q_full, q_empty;

  // Only the word-index bits of the PC select an entry.
  logic   unused_bits;
  assign unused_bits = ^{pipe.pred_pc[31:IDX_W+2], pipe.pred_pc[1:0], 1'(G_DEPTH)};

`ifdef BHT_GSHARE_EN
  logic [G_DEPTH-1:0] ghr_q, ghr_d;
  assign lookup_idx = pipe.pred_pc[IDX_W+1:2] ^ idx_t'(ghr_q);
`else
  assign lookup_idx = pipe.pred_pc[IDX_W+1:2];
`endif

  // Flush closes both handshakes for the cycle it is asserted.
  assign accept_ok = (state_q == RUN) & ~pipe.flush_req;
  // A full queue steals the port from lookups; otherwise lookups win.
  assign drain     = accept_ok & ~q_empty & (q_full | ~pipe.pred_req);
  assign pipe.pred_ready = accept_ok & ~q_full;
  assign lookup    = pipe.pred_req & pipe.pred_ready;

  assign pipe.upd_ready = accept_ok & (~q_full | drain);
  assign upd_fire  = pipe.upd_valid & pipe.upd_ready;
  assign upd_next  = sat_update(pipe.upd_cnt, pipe.upd_taken);
  // Saturated counters need no write.
  assign push      = upd_fire & (upd_next != pipe.upd_cnt);

  bht_upd_fifo #(
    .DEPTH (UQ_DEPTH),
    .W     (IDX_W + 2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (pipe.flush_req),
    .push_i  (push),
    .pop_i   (drain),
    .wdata_i ({pipe.upd_idx, upd_next}),
    .rdata_o ({head_idx, head_cnt}),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = CNT_INIT;
    if (state_q == CLEAR) begin
      tbl_en    = 1'b1;
      tbl_we    = 1'b1;
      tbl_addr  = clear_idx_q;
    end else if (drain) begin
      tbl_en    = 1'b1;
      tbl_we    = 1'b1;
      tbl_addr  = head_idx;
      tbl_wdata = head_cnt;
    end else if (lookup) begin
      tbl_en    = 1'b1;
      tbl_addr  = lookup_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= CLEAR;
      clear_idx_q  <= '0;
      pred_valid_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      // An in-flight lookup still completes across a flush.
      pred_valid_q <= lookup;
      if (lookup) pred_idx_q <= lookup_idx;
      if (pipe.flush_req) begin
        state_q     <= CLEAR;
        clear_idx_q <= '0;
      end else if (state_q == CLEAR) begin
        if (clear_idx_q == idx_t'(DEPTH - 1)) state_q <= RUN;
        clear_idx_q <= clear_idx_q + idx_t'(1);
      end
    end
  end

`ifdef BHT_GSHARE_EN
  always_comb begin
    ghr_d = ghr_q;
    if (pipe.flush_req) begin
      ghr_d = '0;
    end else if (upd_fire) begin
      ghr_d    = ghr_q << 1;
      ghr_d[0] = pipe.upd_taken;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ghr_q <= '0;
    else          ghr_q <= ghr_d;
  end
`endif

  // Read data is only meaningful in the cycle after a lookup.
  assign pred_cnt_w      = pred_valid_q ? tbl_rdata : '0;
  assign pipe.pred_cnt   = pred_cnt_w;
  assign pipe.pred_taken = pred_cnt_w[1];
  assign pipe.pred_valid = pred_valid_q;
  assign pipe.pred_idx   = pred_idx_q;
  assign pipe.clear_busy = (state_q == CLEAR);

endmodule
